vga_plot_buffer: RTL and testbench

Downstream stage of the display controller: accepts its per-cycle pixel plot stream (plot strobe, x, y, 3-bit color), filters off-screen coordinates, buffers plots in a 16-entry FIFO and issues them to the VGA adapter's framebuffer write port at a programmable rate. It also contains a full-screen clear engine that sweeps every pixel to a fixed color on request, used at level start and game over. Input is never back-pressured; losses are reported through sticky status.

---
 rtl/vga_plot_buffer_if.sv | 11 +
 rtl/vga_plot_buffer.sv | 132 +++++++++++++
 tb/tb_vga_plot_buffer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_plot_buffer_if.sv
// Pixel plot bus: one strobe per pixel with its coordinates and color.
// Used both for the incoming plot stream and for the framebuffer write port.
interface vga_plot_buffer_if;
   logic       plot;
   logic [7:0] x;
   logic [7:0] y;
   logic [2:0] color;

   modport master (output plot, x, y, color);
   modport slave  (input  plot, x, y, color);
endinterface

// File: rtl/vga_plot_buffer.sv
// Buffers on-screen pixel plots and paces them into the VGA framebuffer write
// port; a clear engine can take over the port and sweep the whole screen.
module vga_plot_buffer #(
   parameter int         WRITE_INTERVAL = 1,
   parameter logic [2:0] CLEAR_COLOR    = 3'b000,
   parameter int         FIFO_DEPTH     = 16
) (
   input  logic                     clock_50,
   input  logic                     reset,
   vga_plot_buffer_if.slave         pixel,
   vga_plot_buffer_if.master        vga,
   input  logic                     clear_req,
   output logic                     busy,
   output logic [4:0]               fifo_level,
   output logic                     overflow,
   output logic [7:0]               drop_count
);
   localparam int         AW          = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int         PW          = (WRITE_INTERVAL > 1) ? $clog2(WRITE_INTERVAL) : 1;
   localparam logic [PW-1:0] PACE_RELOAD = PW'(WRITE_INTERVAL - 1);
   localparam logic [4:0] DEPTH_L     = 5'(FIFO_DEPTH);
   localparam logic [7:0] X_LAST      = 8'd159;
   localparam logic [7:0] Y_LAST      = 8'd119;

   typedef enum logic {IDLE, CLEAR} state_t;
   state_t state_reg, state_next;

   logic [18:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [4:0]    count_reg;
   logic [PW-1:0] pace_reg;
   logic [7:0]    sweep_x_reg, sweep_y_reg;
   logic          plot_reg;
   logic [7:0]    x_reg, y_reg;
   logic [2:0]    color_reg;
   logic          overflow_reg;
   logic [7:0]    drop_reg;

   logic in_range, fifo_empty, fifo_full, pace_zero, sweep_last;
   logic pop, push, clear_issue, drop_full, drop_any, clear_start;

   // Control decode: who owns the write port this edge and what happens to the input.
   always_comb begin
      in_range    = pixel.plot && (pixel.x < 8'd160) && (pixel.y < 8'd120);
      fifo_empty  = (count_reg == 5'd0);
      fifo_full   = (count_reg == DEPTH_L);
      pace_zero   = (pace_reg == '0);
      sweep_last  = (sweep_x_reg == X_LAST) && (sweep_y_reg == Y_LAST);
      pop         = (state_reg == IDLE) && !fifo_empty && pace_zero;
      clear_issue = (state_reg == CLEAR) && pace_zero;
      push        = (state_reg == IDLE) && in_range && (!fifo_full || pop);
      drop_full   = (state_reg == IDLE) && in_range && fifo_full && !pop;
      drop_any    = drop_full || ((state_reg == CLEAR) && in_range);
      clear_start = (state_reg == IDLE) && clear_req;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (clear_req) state_next = CLEAR;
         CLEAR:   if (clear_issue && sweep_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock_50) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clock_50) begin
      if (push) mem[wr_ptr_reg] <= {pixel.x, pixel.y, pixel.color};
   end

   always_ff @(posedge clock_50) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= 5'd0;
         pace_reg     <= '0;
         sweep_x_reg  <= 8'd0;
         sweep_y_reg  <= 8'd0;
         plot_reg     <= 1'b0;
         x_reg        <= 8'd0;
         y_reg        <= 8'd0;
         color_reg    <= 3'd0;
         overflow_reg <= 1'b0;
         drop_reg     <= 8'd0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         count_reg <= count_reg + 5'(push) - 5'(pop);

         if (pop || clear_issue) pace_reg <= PACE_RELOAD;
         else if (!pace_zero)    pace_reg <= pace_reg - PW'(1);

         if (clear_start) begin
            sweep_x_reg <= 8'd0;
            sweep_y_reg <= 8'd0;
         end else if (clear_issue) begin
            if (sweep_x_reg == X_LAST) begin
               sweep_x_reg <= 8'd0;
               sweep_y_reg <= (sweep_y_reg == Y_LAST) ? 8'd0 : sweep_y_reg + 8'd1;
            end else begin
               sweep_x_reg <= sweep_x_reg + 8'd1;
            end
         end

         // Output registers double as the FIFO's registered read port.
         plot_reg <= pop || clear_issue;
         if (pop) begin
            {x_reg, y_reg, color_reg} <= mem[rd_ptr_reg];
         end else if (clear_issue) begin
            x_reg     <= sweep_x_reg;
            y_reg     <= sweep_y_reg;
            color_reg <= CLEAR_COLOR;
         end

         if (drop_full) overflow_reg <= 1'b1;
         if (drop_any && (drop_reg != 8'hFF)) drop_reg <= drop_reg + 8'd1;
      end
   end

   assign vga.plot   = plot_reg;
   assign vga.x      = x_reg;
   assign vga.y      = y_reg;
   assign vga.color  = color_reg;
   assign busy       = (state_reg == CLEAR);
   assign fifo_level = count_reg;
   assign overflow   = overflow_reg;
   assign drop_count = drop_reg;
endmodule

// File: tb/tb_vga_plot_buffer.sv
// Scoreboard bench: three plot buffers with write intervals 1, 2 and 4 are
// exercised one at a time; every framebuffer write is matched against a queue.
module tb_vga_plot_buffer;
   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;

   logic       drv_plot [N];
   logic [7:0] drv_x [N];
   logic [7:0] drv_y [N];
   logic [2:0] drv_color [N];
   logic       drv_clear [N];
   logic       obs_plot [N];
   logic [7:0] obs_x [N];
   logic [7:0] obs_y [N];
   logic [2:0] obs_color [N];
   logic       obs_busy [N];
   logic [4:0] obs_level [N];
   logic       obs_ovf [N];
   logic [7:0] obs_drop [N];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_dut
         vga_plot_buffer_if pix ();
         vga_plot_buffer_if vga ();
         assign pix.plot  = drv_plot[gi];
         assign pix.x     = drv_x[gi];
         assign pix.y     = drv_y[gi];
         assign pix.color = drv_color[gi];
         vga_plot_buffer #(
            .WRITE_INTERVAL (gi == 0 ? 1 : (gi == 1 ? 2 : 4)),
            .CLEAR_COLOR    (gi == 1 ? 3'b110 : 3'b000),
            .FIFO_DEPTH     (16)
         ) u_dut (
            .clock_50   (clk),
            .reset      (reset),
            .pixel      (pix),
            .vga        (vga),
            .clear_req  (drv_clear[gi]),
            .busy       (obs_busy[gi]),
            .fifo_level (obs_level[gi]),
            .overflow   (obs_ovf[gi]),
            .drop_count (obs_drop[gi])
         );
         assign obs_plot[gi]  = vga.plot;
         assign obs_x[gi]     = vga.x;
         assign obs_y[gi]     = vga.y;
         assign obs_color[gi] = vga.color;
      end
   endgenerate

   function automatic int wi_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
   endfunction

   function automatic logic [2:0] cc_of(input int d);
      return (d == 1) ? 3'b110 : 3'b000;
   endfunction

   typedef struct {
      int         dut;
      logic [7:0] x;
      logic [7:0] y;
      logic [2:0] color;
      logic       busy;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int wr_cnt [N] = '{0, 0, 0};
   int last_cyc [N] = '{-1, -1, -1};

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every write strobe must match the head of the queue.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < N; d++) begin
         if (obs_plot[d] === 1'b1) begin
            if (sb.size() == 0 || sb[0].dut != d) begin
               check_val("spurious_write", 32'(d + 1), 32'd0);
            end else begin
               e = sb.pop_front();
               check_val("wr_data", {13'd0, obs_x[d], obs_y[d], obs_color[d]},
                         {13'd0, e.x, e.y, e.color});
               check_val("wr_busy", 32'(obs_busy[d]), 32'(e.busy));
            end
            wr_cnt[d]++;
            if (d > 0 && last_cyc[d] >= 0) check_val("wr_gap", 32'(cyc - last_cyc[d]), 32'(wi_of(d)));
            last_cyc[d] = cyc;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_raw(input int d, input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
      drv_plot[d]  = 1'b1;
      drv_x[d]     = x;
      drv_y[d]     = y;
      drv_color[d] = c;
      $display("plot dut%0d x=%0d y=%0d c=%0d", d, x, y, c);
   endtask

   task automatic send(input int d, input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
      drive_raw(d, x, y, c);
      sb.push_back('{d, x, y, c, 1'b0});
   endtask

   task automatic idle(input int d);
      drv_plot[d] = 1'b0;
   endtask

   task automatic push_clear(input int d);
      for (int yy = 0; yy < 120; yy++)
         for (int xx = 0; xx < 160; xx++)
            sb.push_back('{d, 8'(xx), 8'(yy), cc_of(d), !(xx == 159 && yy == 119)});
   endtask

   task automatic check_all_zero(input string tag);
      for (int d = 0; d < N; d++) begin
         check_val({tag, "_plot"},  32'(obs_plot[d]),  32'd0);
         check_val({tag, "_xyc"},   {13'd0, obs_x[d], obs_y[d], obs_color[d]}, 32'd0);
         check_val({tag, "_busy"},  32'(obs_busy[d]),  32'd0);
         check_val({tag, "_level"}, 32'(obs_level[d]), 32'd0);
         check_val({tag, "_ovf"},   32'(obs_ovf[d]),   32'd0);
         check_val({tag, "_drop"},  32'(obs_drop[d]),  32'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int m_cnt, m_pace, m_drops, n, base, snap;
      logic pop_m, acc_m;
      exp_t held[$];

      reset = 1'b1;
      for (int d = 0; d < N; d++) begin
         drv_plot[d] = 1'b0; drv_x[d] = 8'd0; drv_y[d] = 8'd0;
         drv_color[d] = 3'd0; drv_clear[d] = 1'b0;
      end
      repeat (3) tick();
      $display("reset all");
      check_all_zero("rst");
      reset = 1'b0;
      tick();

      // Single plot: two-cycle latency through the FIFO.
      send(0, 8'd10, 8'd20, 3'd5);
      tick();
      check_val("lat_k_plot", 32'(obs_plot[0]), 32'd0);
      check_val("lat_k_level", 32'(obs_level[0]), 32'd1);
      idle(0);
      tick();
      check_val("lat_k1_plot", 32'(obs_plot[0]), 32'd1);
      check_val("lat_k1_level", 32'(obs_level[0]), 32'd0);
      tick();
      check_val("lat_k2_plot", 32'(obs_plot[0]), 32'd0);

      // Off-screen plots are discarded silently.
      drive_raw(0, 8'd160, 8'd0, 3'd1);
      tick();
      drive_raw(0, 8'd0, 8'd120, 3'd2);
      tick();
      idle(0);
      repeat (4) tick();
      check_val("offscr_drop", 32'(obs_drop[0]), 32'd0);
      check_val("offscr_level", 32'(obs_level[0]), 32'd0);
      check_val("offscr_ovf", 32'(obs_ovf[0]), 32'd0);

      // Back-to-back at interval 1: one write per cycle, occupancy never above 1.
      for (int i = 0; i < 8; i++) begin
         send(0, 8'(30 + i), 8'(40 + i), 3'(i));
         tick();
         check_val("b2b_level_le1", 32'(obs_level[0] <= 5'd1), 32'd1);
      end
      idle(0);
      repeat (4) tick();
      check_val("b2b_drain", 32'(sb.size()), 32'd0);

      // Interval 4 burst: occupancy model decides which plots overflow.
      m_cnt = 0; m_pace = 0; m_drops = 0;
      for (int i = 0; i < 27; i++) begin
         pop_m = (m_cnt > 0) && (m_pace == 0);
         acc_m = (m_cnt < 16) || pop_m;
         if (acc_m) send(2, 8'(i * 5), 8'(i * 3), 3'(i));
         else begin
            drive_raw(2, 8'(i * 5), 8'(i * 3), 3'(i));
            m_drops++;
         end
         m_cnt = m_cnt + int'(acc_m) - int'(pop_m);
         m_pace = pop_m ? wi_of(2) - 1 : ((m_pace > 0) ? m_pace - 1 : 0);
         tick();
      end
      idle(2);
      check_val("ovf_level", 32'(obs_level[2]), 32'(m_cnt));
      check_val("ovf_drops", 32'(obs_drop[2]), 32'(m_drops));
      check_val("ovf_flag", 32'(obs_ovf[2]), 32'(m_drops > 0));
      n = 0;
      while ((sb.size() > 0 || obs_level[2] != 5'd0) && n < 200) begin tick(); n++; end
      check_val("ovf_drain", 32'(sb.size()), 32'd0);
      check_val("ovf_drop_hold", 32'(obs_drop[2]), 32'(m_drops));

      // Interval 2: five plots, clear_req with the last; three stay buffered.
      for (int i = 0; i < 5; i++) begin
         if (i < 2) send(1, 8'(100 + i), 8'(50 + i), 3'(i + 1));
         else begin
            drive_raw(1, 8'(100 + i), 8'(50 + i), 3'(i + 1));
            held.push_back('{1, 8'(100 + i), 8'(50 + i), 3'(i + 1), 1'b0});
         end
         if (i == 4) begin
            drv_clear[1] = 1'b1;
            $display("clear_req dut1");
            push_clear(1);
            while (held.size() > 0) sb.push_back(held.pop_front());
         end
         tick();
      end
      drv_clear[1] = 1'b0;
      idle(1);
      check_val("clr_busy_k", 32'(obs_busy[1]), 32'd1);
      check_val("clr_level_k", 32'(obs_level[1]), 32'd3);
      repeat (10) tick();
      for (int i = 0; i < 5; i++) begin
         drive_raw(1, 8'(i), 8'(i), 3'd7);
         drv_clear[1] = (i == 2);
         tick();
      end
      idle(1);
      drv_clear[1] = 1'b0;
      check_val("clr_drop_mid", 32'(obs_drop[1]), 32'd5);
      check_val("clr_level_mid", 32'(obs_level[1]), 32'd3);
      n = 0;
      while (obs_busy[1] && n < 40000) begin tick(); n++; end
      check_val("clr_done", 32'(obs_busy[1]), 32'd0);
      n = 0;
      while (sb.size() > 0 && n < 50) begin tick(); n++; end
      tick();
      check_val("clr_sb_empty", 32'(sb.size()), 32'd0);
      check_val("clr_level_end", 32'(obs_level[1]), 32'd0);
      check_val("clr_drop_end", 32'(obs_drop[1]), 32'd5);
      check_val("clr_ovf_end", 32'(obs_ovf[1]), 32'd0);
      check_val("clr_wr_total", 32'(wr_cnt[1]), 32'd19205);

      // Reset in the middle of a clear sweep.
      base = wr_cnt[0];
      drv_clear[0] = 1'b1;
      $display("clear_req dut0");
      push_clear(0);
      tick();
      drv_clear[0] = 1'b0;
      n = 0;
      while (wr_cnt[0] < base + 500 && n < 1000) begin tick(); n++; end
      check_val("mid_clr_reached", 32'(wr_cnt[0] - base), 32'd500);
      reset = 1'b1;
      $display("reset all mid-clear");
      tick();
      check_all_zero("midrst");
      sb.delete();
      snap = wr_cnt[0];
      reset = 1'b0;
      repeat (30) tick();
      check_val("midrst_no_writes", 32'(wr_cnt[0] - snap), 32'd0);
      check_val("midrst_busy", 32'(obs_busy[0]), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
